// File: rtl/frogger_pkg.sv
// Shared grid geometry, FSM state encoding and sentinel values for the
// frogger collision/lives logic.
package frogger_pkg;

  localparam int unsigned GRID_COLS = 21;
  localparam int unsigned X_W       = 5;
  localparam int unsigned Y_W       = 4;
  localparam int unsigned LIVES_W   = 3;

  localparam logic [X_W-1:0] NO_CAR = 5'd31;

  typedef enum logic [1:0] {
    PLAYING   = 2'd0,
    HIT       = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

endpackage

// File: rtl/lane_hit_check.sv
// Combinational overlap test of the frog column against one car that spans
// CAR_WIDTH cells from car_x with wrap around the 21-column grid.
module lane_hit_check
  import frogger_pkg::*;
#(
  parameter int unsigned CAR_WIDTH = 2
) (
  input  logic [X_W-1:0] i_frog_x,
  input  logic [X_W-1:0] i_car_x,
  output logic           o_overlap
);

  localparam int unsigned D_W = X_W + 2;

  logic [D_W-1:0] w_diff;
  logic [D_W-1:0] w_dist;

  // Modular distance without a divide: subtract, add one grid width if negative.
  always_comb begin
    w_diff    = {2'b00, i_frog_x} - {2'b00, i_car_x};
    w_dist    = w_diff[D_W-1] ? (w_diff + D_W'(GRID_COLS)) : w_diff;
    o_overlap = (i_car_x <= X_W'(GRID_COLS - 1)) && (w_dist < D_W'(CAR_WIDTH));
  end

endmodule

// File: rtl/frog_collision.sv
// Scans one car lane per clock against the frog and sequences hit, freeze,
// respawn, goal and game-over, owning the lives counter.
module frog_collision
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned LANE_ROW0    = 2,
  parameter int unsigned CAR_WIDTH    = 2,
  parameter int unsigned GOAL_ROW     = 7,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned FREEZE_TICKS = 25000000
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic [X_W-1:0]           i_frog_x,
  input  logic [Y_W-1:0]           i_frog_y,
  input  logic [X_W*NUM_LANES-1:0] i_car_x,
  input  logic                     i_restart,
  output logic                     o_hit,
  output logic                     o_goal,
  output logic                     o_respawn,
  output logic                     o_freeze,
  output logic [LIVES_W-1:0]       o_lives,
  output logic                     o_game_over
);

  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;

  state_t             r_state,    w_state_nxt;
  logic [IDX_W-1:0]   r_scan_idx, w_scan_nxt;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
  logic [LIVES_W-1:0] r_lives,    w_lives_nxt;

  logic [X_W-1:0] w_cars [NUM_LANES];
  logic [X_W-1:0] w_car;
  logic [Y_W-1:0] w_lane_row;
  logic           w_overlap;
  logic           w_collide;

  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      w_cars[k] = i_car_x[k*X_W +: X_W];
    end
    w_car      = w_cars[r_scan_idx];
    w_lane_row = Y_W'(LANE_ROW0) + Y_W'(r_scan_idx);
    w_collide  = (i_frog_y == w_lane_row) && w_overlap;
  end

  lane_hit_check #(
    .CAR_WIDTH(CAR_WIDTH)
  ) u_lane_hit_check (
    .i_frog_x (i_frog_x),
    .i_car_x  (w_car),
    .o_overlap(w_overlap)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state    <= PLAYING;
      r_scan_idx <= '0;
      r_cnt      <= '0;
      r_lives    <= LIVES_W'(START_LIVES);
    end else begin
      r_state    <= w_state_nxt;
      r_scan_idx <= w_scan_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lives    <= w_lives_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scan_nxt  = '0;
    w_cnt_nxt   = r_cnt;
    w_lives_nxt = r_lives;
    o_hit       = 1'b0;
    o_goal      = 1'b0;
    o_respawn   = 1'b0;
    o_freeze    = 1'b0;
    o_game_over = 1'b0;

    unique case (r_state)
      PLAYING: begin
        w_scan_nxt = (r_scan_idx == IDX_W'(NUM_LANES - 1)) ? '0 : r_scan_idx + 1'b1;
        if (w_collide) begin
          o_hit      = 1'b1;
          w_scan_nxt = '0;
          if (r_lives > LIVES_W'(1)) begin
            w_lives_nxt = r_lives - 1'b1;
            w_cnt_nxt   = CNT_W'(FREEZE_TICKS - 1);
            w_state_nxt = HIT;
          end else begin
            w_lives_nxt = '0;
            w_state_nxt = GAME_OVER;
          end
        end else if (i_frog_y == Y_W'(GOAL_ROW)) begin
          o_goal      = 1'b1;
          w_scan_nxt  = '0;
          w_state_nxt = RESPAWN;
        end
      end
      HIT: begin
        o_freeze = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = RESPAWN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESPAWN: begin
        o_respawn   = 1'b1;
        w_state_nxt = PLAYING;
      end
      GAME_OVER: begin
        o_freeze    = 1'b1;
        o_game_over = 1'b1;
        if (i_restart) begin
          w_lives_nxt = LIVES_W'(START_LIVES);
          w_state_nxt = RESPAWN;
        end
      end
      default: w_state_nxt = PLAYING;
    endcase

    // Pulses are suppressed while reset is held so an aborted freeze never respawns.
    if (i_Reset) begin
      o_hit     = 1'b0;
      o_goal    = 1'b0;
      o_respawn = 1'b0;
    end
  end

  assign o_lives = r_lives;

endmodule

// File: tb/tb_frog_collision.sv
// Randomized and directed bench for frog_collision against a cycle-level
// reference model built from the game rules.
module tb_frog_collision;
  import frogger_pkg::*;

  localparam int NL = 4;
  localparam int FT = 8;
  localparam int SL = 3;

  localparam int P_PLAY = 0;
  localparam int P_FRZ  = 1;
  localparam int P_RESP = 2;
  localparam int P_OVER = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    frog_x;
  logic [3:0]    frog_y;
  logic [NL*5-1:0] car;
  logic          restart;
  logic          o_hit, o_goal, o_respawn, o_freeze, o_game_over;
  logic [2:0]    o_lives;

  int n_vec = 0;
  int n_err = 0;

  int m_phase, m_lives, m_left, m_scan;
  int seen_hit, seen_resp, seen_freeze;
  int last_hit, last_goal, last_resp;

  always #20 clk = ~clk;

  frog_collision #(
    .NUM_LANES   (NL),
    .LANE_ROW0   (2),
    .CAR_WIDTH   (2),
    .GOAL_ROW    (7),
    .START_LIVES (SL),
    .FREEZE_TICKS(FT)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_frog_x   (frog_x),
    .i_frog_y   (frog_y),
    .i_car_x    (car),
    .i_restart  (restart),
    .o_hit      (o_hit),
    .o_goal     (o_goal),
    .o_respawn  (o_respawn),
    .o_freeze   (o_freeze),
    .o_lives    (o_lives),
    .o_game_over(o_game_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit covers(int fx, int cx);
    if (cx > 20) return 1'b0;
    return ((fx - cx + 21) % 21) < 2;
  endfunction

  function automatic int lane_car(int k);
    logic [4:0] v;
    v = car[k*5 +: 5];
    return int'(v);
  endfunction

  // One clock: compare at negedge against the model, advance the model, then
  // return just after the next rising edge ready for new inputs.
  task automatic cyc();
    bit collide;
    int e_hit, e_goal, e_resp;
    @(negedge clk);
    collide = (m_phase == P_PLAY) && (int'(frog_y) == 2 + m_scan)
              && covers(int'(frog_x), lane_car(m_scan));
    e_hit  = 0;
    e_goal = 0;
    e_resp = 0;
    if (!rst) begin
      if (m_phase == P_PLAY) begin
        e_hit  = collide;
        e_goal = !collide && (frog_y == 4'd7);
      end
      e_resp = (m_phase == P_RESP);
    end
    check("hit",       o_hit,       e_hit);
    check("goal",      o_goal,      e_goal);
    check("respawn",   o_respawn,   e_resp);
    check("freeze",    o_freeze,    (m_phase == P_FRZ) || (m_phase == P_OVER));
    check("game_over", o_game_over, m_phase == P_OVER);
    check("lives",     o_lives,     m_lives);
    last_hit  = o_hit;
    last_goal = o_goal;
    last_resp = o_respawn;
    seen_hit    += o_hit;
    seen_resp   += o_respawn;
    seen_freeze += o_freeze;

    if (rst) begin
      m_phase = P_PLAY;
      m_scan  = 0;
      m_lives = SL;
    end else begin
      case (m_phase)
        P_PLAY: begin
          if (collide) begin
            m_scan = 0;
            if (m_lives > 1) begin
              m_lives--;
              m_left  = FT;
              m_phase = P_FRZ;
            end else begin
              m_lives = 0;
              m_phase = P_OVER;
            end
          end else if (frog_y == 4'd7) begin
            m_scan  = 0;
            m_phase = P_RESP;
          end else begin
            m_scan = (m_scan + 1) % NL;
          end
        end
        P_FRZ: begin
          m_left--;
          if (m_left == 0) m_phase = P_RESP;
        end
        P_RESP: m_phase = P_PLAY;
        default: begin
          if (restart) begin
            m_lives = SL;
            m_phase = P_RESP;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_cars(input int c0, input int c1, input int c2, input int c3);
    car = {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endtask

  task automatic wait_hit(input string tag, input int expect_hit);
    int got;
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      cyc();
      got = last_hit;
    end
    check(tag, got, expect_hit);
  endtask

  task automatic lane0_hit(input string tag);
    frog_x = 5'd5;
    frog_y = 4'd2;
    set_cars(5, 31, 31, 31);
    wait_hit(tag, 1);
    frog_y = 4'd0;
  endtask

  initial begin
    int h0, r0, f0;
    m_phase = P_PLAY; m_lives = SL; m_left = 0; m_scan = 0;
    seen_hit = 0; seen_resp = 0; seen_freeze = 0;
    last_hit = 0; last_goal = 0; last_resp = 0;
    rst = 1'b1; restart = 1'b0; frog_x = '0; frog_y = '0;
    set_cars(5, 5, 5, 5);
    #1;
    do_reset();

    h0 = seen_hit;
    run(100);
    check("idle_no_hit", seen_hit - h0, 0);
    check("idle_lives", o_lives, 3);

    lane0_hit("first_hit");
    h0 = seen_hit; r0 = seen_resp; f0 = seen_freeze;
    run(15);
    check("freeze_len", seen_freeze - f0, FT);
    check("respawn_once", seen_resp - r0, 1);
    check("lives_after_hit", o_lives, 2);

    do_reset();
    frog_y = 4'd3; frog_x = 5'd0;
    set_cars(31, 20, 31, 31);
    wait_hit("wrap_hit", 1);
    frog_y = 4'd0;
    run(12);
    frog_y = 4'd3;
    h0 = seen_hit;
    frog_x = 5'd1;  run(8);
    frog_x = 5'd19; run(8);
    set_cars(31, 31, 31, 31);
    for (int x = 0; x <= 20; x += 4) begin
      frog_x = 5'(x);
      run(4);
    end
    check("wrap_misses", seen_hit - h0, 0);

    do_reset();
    restart = 1'b1; run(2); restart = 1'b0;
    lane0_hit("hit1"); run(12);
    lane0_hit("hit2"); run(12);
    r0 = seen_resp;
    lane0_hit("hit3");
    check("go_flag", o_game_over, 1);
    frog_y = 4'd2;
    h0 = seen_hit;
    run(20);
    check("go_no_hit", seen_hit - h0, 0);
    check("go_no_respawn", seen_resp - r0, 0);
    check("go_lives", o_lives, 0);
    frog_y = 4'd0;
    restart = 1'b1; cyc(); restart = 1'b0;
    run(3);
    check("restart_lives", o_lives, 3);
    check("restart_respawn", seen_resp - r0, 1);

    frog_y = 4'd7; cyc();
    check("goal_pulse", last_goal, 1);
    frog_y = 4'd0; cyc();
    check("goal_respawn", last_resp, 1);
    check("goal_lives", o_lives, 3);

    lane0_hit("pre_abort_hit");
    run(2);
    r0 = seen_resp;
    rst = 1'b1; cyc(); rst = 1'b0;
    check("abort_freeze", o_freeze, 0);
    check("abort_lives", o_lives, 3);
    run(12);
    check("abort_no_respawn", seen_resp - r0, 0);

    for (int i = 0; i < 3000; i++) begin
      frog_x  = 5'($urandom_range(0, 20));
      frog_y  = 4'($urandom_range(0, 8));
      restart = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0)
        set_cars($urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31));
      cyc();
    end
    rst = 1'b0; restart = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
